// File: rtl/irr_isr_priority_resolver.sv
// 8259 IRR/ISR stage: request capture, masking, fixed/rotating priority, INTA and EOI handling.
// Optional poll-command support is enabled by defining PIC_POLL_MODE_EN.
module irr_isr_priority_resolver #(
    parameter int         NUM_IR     = 8,
    parameter logic [2:0] RESET_LOWP = 3'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir_in,
    input  logic       ltim,
    input  logic [7:0] imr,
    input  logic       special_mask_mode,
    input  logic       aeoi,
    input  logic       auto_rotate,
    input  logic       inta,
    input  logic       eoi_nonspecific,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       poll_read,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic       int_req,
    output logic [2:0] highest_priority_isr,
    output logic [2:0] ack_level,
    output logic [7:0] poll_word
);

    typedef enum logic {IDLE, ACK2} state_t;

    state_t     state_reg, state_next;
    logic [7:0] irr_reg, irr_next, isr_reg, isr_next, ir_q_reg;
    logic [7:0] poll_word_reg, poll_word_next, ir_rise;
    logic [2:0] lowp_reg, lowp_next, ack_level_reg, ack_level_next;
    logic       inta_q_reg, int_req_reg, int_req_next, ack_valid_reg, ack_valid_next;
    logic [3:0] isr_top, pend_top, blk_top, eoi_top, win;
    logic [7:0] pend, blk, isr_eoi;
    logic [2:0] lowp_eoi;
    logic       inta_fall, take;

    // Returns {found, level}; the level just after lowp has the highest priority.
    function automatic logic [3:0] resolve(input logic [7:0] v, input logic [2:0] lowp);
        logic [2:0] lvl;
        resolve = {1'b0, 3'd7};
        for (int k = NUM_IR; k >= 1; k--) begin
            lvl = lowp + 3'(k);
            if (v[lvl]) resolve = {1'b1, lvl};
        end
    endfunction

    function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] lowp);
        rank = lvl - lowp - 3'd1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IR; gi++) begin : g_edge
            assign ir_rise[gi] = ir_in[gi] & ~ir_q_reg[gi];
        end
    endgenerate

    assign inta_fall = inta_q_reg & ~inta;
    assign pend      = irr_reg & ~imr;
    assign blk       = special_mask_mode ? (isr_reg & ~imr) : isr_reg;
    assign isr_top   = resolve(isr_reg, lowp_reg);
    assign pend_top  = resolve(pend, lowp_reg);
    assign blk_top   = resolve(blk, lowp_reg);
    assign eoi_top   = isr_top;

    // EOI is applied before any acknowledge resolved in the same cycle.
    always_comb begin
        isr_eoi  = isr_reg;
        lowp_eoi = lowp_reg;
        if (eoi_specific) begin
            isr_eoi[eoi_level] = 1'b0;
        end else if (eoi_nonspecific && eoi_top[3]) begin
            isr_eoi[eoi_top[2:0]] = 1'b0;
            if (auto_rotate) lowp_eoi = eoi_top[2:0];
        end
    end

    assign win = resolve(pend, lowp_eoi);

    always_comb begin
        state_next     = state_reg;
        irr_next       = ltim ? ir_in : (irr_reg | ir_rise);
        isr_next       = isr_eoi;
        lowp_next      = lowp_eoi;
        ack_level_next = ack_level_reg;
        ack_valid_next = ack_valid_reg;
        poll_word_next = poll_word_reg;
        take           = 1'b0;

        if (state_reg == IDLE) begin
            if (inta_fall) begin
                state_next     = ACK2;
                take           = 1'b1;
                ack_level_next = win[3] ? win[2:0] : 3'd7;
                ack_valid_next = win[3];
            end
`ifdef PIC_POLL_MODE_EN
            else if (poll_read) begin
                take           = 1'b1;
                poll_word_next = {int_req_reg, 4'b0000, win[2:0]};
            end
`endif
        end else if (inta_fall) begin
            state_next = IDLE;
            if (aeoi && ack_valid_reg) begin
                isr_next[ack_level_reg] = 1'b0;
                if (auto_rotate) lowp_next = ack_level_reg;
            end
        end

        if (take && win[3]) begin
            isr_next[win[2:0]] = 1'b1;
            if (!ltim) irr_next[win[2:0]] = 1'b0;
        end

`ifndef PIC_POLL_MODE_EN
        // Poll is unsupported in this build; the strobe is deliberately masked off.
        poll_word_next = 8'h00 & {8{poll_read}};
`endif

        int_req_next = pend_top[3] &&
                       (!blk_top[3] || (rank(pend_top[2:0], lowp_reg) < rank(blk_top[2:0], lowp_reg)));
        if (state_next == ACK2) int_req_next = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            irr_reg       <= 8'h00;
            isr_reg       <= 8'h00;
            ir_q_reg      <= 8'h00;
            inta_q_reg    <= 1'b1;
            lowp_reg      <= RESET_LOWP;
            ack_level_reg <= 3'd7;
            ack_valid_reg <= 1'b0;
            int_req_reg   <= 1'b0;
            poll_word_reg <= 8'h00;
        end else begin
            state_reg     <= state_next;
            irr_reg       <= irr_next;
            isr_reg       <= isr_next;
            ir_q_reg      <= ir_in;
            inta_q_reg    <= inta;
            lowp_reg      <= lowp_next;
            ack_level_reg <= ack_level_next;
            ack_valid_reg <= ack_valid_next;
            int_req_reg   <= int_req_next;
            poll_word_reg <= poll_word_next;
        end
    end

    assign irr                  = irr_reg;
    assign isr                  = isr_reg;
    assign int_req              = int_req_reg;
    assign highest_priority_isr = isr_top[2:0];
    assign ack_level            = ack_level_reg;
    assign poll_word            = poll_word_reg;

endmodule

// File: tb/tb_irr_isr_priority_resolver.sv
// Directed and randomized checks of irr_isr_priority_resolver against a behavioural model.
module tb_irr_isr_priority_resolver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ir_in = 8'h00, imr = 8'h00;
    logic       ltim = 1'b0, special_mask_mode = 1'b0, aeoi = 1'b0, auto_rotate = 1'b0;
    logic       inta = 1'b1, eoi_nonspecific = 1'b0, eoi_specific = 1'b0, poll_read = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic [7:0] irr, isr, poll_word;
    logic       int_req;
    logic [2:0] highest_priority_isr, ack_level;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    bit [7:0] m_irr, m_isr, m_irq, m_poll;
    int       m_lowp, m_ack;
    bit       m_int, m_ack2, m_valid, m_intaq;

    irr_isr_priority_resolver dut (
        .clk(clk), .rst(rst), .ir_in(ir_in), .ltim(ltim), .imr(imr),
        .special_mask_mode(special_mask_mode), .aeoi(aeoi), .auto_rotate(auto_rotate),
        .inta(inta), .eoi_nonspecific(eoi_nonspecific), .eoi_specific(eoi_specific),
        .eoi_level(eoi_level), .poll_read(poll_read), .irr(irr), .isr(isr),
        .int_req(int_req), .highest_priority_isr(highest_priority_isr),
        .ack_level(ack_level), .poll_word(poll_word)
    );

    always #5 clk = ~clk;

    // Highest-priority set level of v when lp is the lowest-priority level; -1 if none.
    function automatic int top(input bit [7:0] v, input int lp);
        for (int r = 0; r < 8; r++) begin
            int l;
            l = (lp + 1 + r) % 8;
            if (v[l]) return l;
        end
        return -1;
    endfunction

    function automatic int prio_rank(input int l, input int lp);
        return (l - lp + 7) % 8;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_irr = 0; m_isr = 0; m_irq = 0; m_poll = 0;
        m_lowp = 7; m_ack = 7; m_int = 0; m_ack2 = 0; m_valid = 0; m_intaq = 1;
    endtask

    task automatic model_step();
        bit       fall;
        bit [7:0] p, b, nirr, nisr;
        int       tp, tb, nlp, t, w;
        bit       ni;
        fall = m_intaq && !inta;
        p    = m_irr & ~imr;
        b    = special_mask_mode ? (m_isr & ~imr) : m_isr;
        tp   = top(p, m_lowp);
        tb   = top(b, m_lowp);
        ni   = (tp >= 0) && (tb < 0 || prio_rank(tp, m_lowp) < prio_rank(tb, m_lowp));
        nirr = ltim ? ir_in : (m_irr | (ir_in & ~m_irq));
        nisr = m_isr;
        nlp  = m_lowp;
        if (eoi_specific) nisr[eoi_level] = 1'b0;
        else if (eoi_nonspecific) begin
            t = top(m_isr, m_lowp);
            if (t >= 0) begin
                nisr[t] = 1'b0;
                if (auto_rotate) nlp = t;
            end
        end
        w = top(p, nlp);
        if (!m_ack2 && fall) begin
            m_ack2  = 1;
            m_valid = (w >= 0);
            m_ack   = (w >= 0) ? w : 7;
            if (w >= 0) begin
                nisr[w] = 1'b1;
                if (!ltim) nirr[w] = 1'b0;
            end
        end
`ifdef PIC_POLL_MODE_EN
        else if (!m_ack2 && poll_read) begin
            m_poll = {m_int, 4'b0000, 3'((w >= 0) ? w : 7)};
            if (w >= 0) begin
                nisr[w] = 1'b1;
                if (!ltim) nirr[w] = 1'b0;
            end
        end
`endif
        else if (m_ack2 && fall) begin
            m_ack2 = 0;
            if (aeoi && m_valid) begin
                nisr[m_ack] = 1'b0;
                if (auto_rotate) nlp = m_ack;
            end
        end
        if (m_ack2) ni = 0;
        m_irr = nirr; m_isr = nisr; m_lowp = nlp; m_int = ni;
        m_irq = ir_in; m_intaq = inta;
    endtask

    task automatic check_all();
        int t;
        t = top(m_isr, m_lowp);
        check("irr", irr, m_irr);
        check("isr", isr, m_isr);
        check("int_req", {7'b0, int_req}, {7'b0, m_int});
        check("highest_isr", {5'b0, highest_priority_isr}, 8'((t < 0) ? 7 : t));
        check("ack_level", {5'b0, ack_level}, 8'(m_ack));
        check("poll_word", poll_word, m_poll);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic inta_pulse();
        inta = 1'b0; cycle();
        inta = 1'b1; cycle();
    endtask

    task automatic check_reset_consts();
        check("rst_irr", irr, 8'h00);
        check("rst_isr", isr, 8'h00);
        check("rst_int", {7'b0, int_req}, 8'h00);
        check("rst_hpi", {5'b0, highest_priority_isr}, 8'h07);
        check("rst_ack", {5'b0, ack_level}, 8'h07);
        check("rst_poll", poll_word, 8'h00);
    endtask

    task automatic do_reset();
        ir_in = 0; imr = 0; ltim = 0; special_mask_mode = 0; aeoi = 0; auto_rotate = 0;
        inta = 1; eoi_nonspecific = 0; eoi_specific = 0; eoi_level = 0; poll_read = 0;
        rst = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check_reset_consts();
        rst = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single edge request, full acknowledge
        ir_in = 8'h40; cycles(2);
        check("t1_irr", irr, 8'h40);
        check("t1_int", {7'b0, int_req}, 8'h01);
        inta_pulse(); inta_pulse();
        check("t1_isr", isr, 8'h40);
        check("t1_irr0", irr, 8'h00);
        check("t1_ack", {5'b0, ack_level}, 8'h06);
        check("t1_int0", {7'b0, int_req}, 8'h00);

        // Fixed priority, non-specific EOI then next acknowledge
        do_reset();
        ir_in = 8'h60; cycles(2);
        inta_pulse();
        check("t2_isr5", isr, 8'h20);
        inta_pulse();
        eoi_nonspecific = 1; cycle(); eoi_nonspecific = 0; cycle();
        check("t2_isr0", isr, 8'h00);
        check("t2_int", {7'b0, int_req}, 8'h01);
        inta_pulse(); inta_pulse();
        check("t2_isr6", isr, 8'h40);

        // Nesting: higher request interrupts, lower does not
        do_reset();
        ir_in = 8'h40; cycles(2); inta_pulse(); inta_pulse();
        ir_in = 8'h44; cycles(2);
        check("t3_int_hi", {7'b0, int_req}, 8'h01);
        inta_pulse(); inta_pulse();
        check("t3_isr", isr, 8'h44);
        eoi_specific = 1; eoi_level = 3'd2; cycle(); eoi_specific = 0;
        ir_in = 8'hC4; cycles(2);
        check("t3_irr", irr, 8'h80);
        check("t3_int_lo", {7'b0, int_req}, 8'h00);

        // AEOI with automatic rotation
        do_reset();
        aeoi = 1; auto_rotate = 1;
        ir_in = 8'h08; cycles(2); inta_pulse(); inta_pulse();
        check("t4_isr", isr, 8'h00);
        check("t4_ack3", {5'b0, ack_level}, 8'h03);
        ir_in = 8'h00; cycle(); ir_in = 8'h12; cycles(2); inta_pulse(); inta_pulse();
        check("t4_ack4", {5'b0, ack_level}, 8'h04);
        ir_in = 8'h00; cycle(); ir_in = 8'h09; cycles(2); inta_pulse(); inta_pulse();
        check("t4_ack0", {5'b0, ack_level}, 8'h00);

        // Spurious acknowledge, then asynchronous reset inside ACK2
        do_reset();
        imr = 8'hFF; ir_in = 8'h01; cycles(2);
        inta = 1'b0; cycle();
        check("t5_ack", {5'b0, ack_level}, 8'h07);
        check("t5_isr", isr, 8'h00);
        rst = 1'b0; #1;
        check_reset_consts();
        model_reset();
        inta = 1'b1; imr = 8'h00;
        @(posedge clk); #1;
        rst = 1'b1;
        cycles(2);

`ifdef PIC_POLL_MODE_EN
        do_reset();
        ir_in = 8'h10; cycles(2);
        poll_read = 1; cycle(); poll_read = 0;
        check("t6_poll", poll_word, 8'h84);
        check("t6_isr", isr, 8'h10);
`else
        do_reset();
        ir_in = 8'h10; cycles(2);
        poll_read = 1; cycle(); poll_read = 0; cycle();
        check("t6_poll0", poll_word, 8'h00);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i % 200 == 0) ltim = $urandom_range(0, 1);
            if (i % 50 == 0) begin
                aeoi        = $urandom_range(0, 1);
                auto_rotate = $urandom_range(0, 1);
            end
            ir_in             = 8'($urandom);
            imr               = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            special_mask_mode = $urandom_range(0, 1);
            inta              = (inta == 1'b0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            eoi_nonspecific   = inta && ($urandom_range(0, 5) == 0);
            eoi_specific      = inta && ($urandom_range(0, 7) == 0);
            eoi_level         = 3'($urandom);
`ifdef PIC_POLL_MODE_EN
            poll_read         = inta && ($urandom_range(0, 9) == 0);
`endif
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
